// File: rtl/sdf_stage_ctrl.sv
// rtl/sdf_stage_ctrl.sv - radix-2^2 SDF stage pair sequencer (optional SDF_CTRL_FRAMECNT_EN frame counter)
module sdf_stage_ctrl #(
    parameter int M      = 64,
    parameter int TW_LAT = 3,
    localparam int LOG_M = $clog2(M)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    output logic             bf1_bf,
    output logic             bf1_do_en,
    output logic             bf2_bf,
    output logic             bf2_ct,
    output logic             bf2_do_en,
    output logic [LOG_M-1:0] tw_addr,
    output logic             do_en,
    output logic             frame_done
`ifdef SDF_CTRL_FRAMECNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    typedef enum logic {EMPTY, STREAM} fill_t;

    localparam logic [LOG_M-1:0] CNT1_PRIME = LOG_M'(M / 2 - 1);
    localparam logic [LOG_M-1:0] CNT2_PRIME = LOG_M'(M / 4 - 1);
    localparam logic [LOG_M-1:0] CNT_LAST   = LOG_M'(M - 1);

    fill_t             state1, state1_nxt;
    fill_t             state2, state2_nxt;
    logic [LOG_M-1:0]  cnt1, cnt2, cnt3, cnt4;
    logic [TW_LAT-1:0] tw_sr;
    logic              bf1_go, bf2_go;
    logic [LOG_M-1:0]  tw_base, tw_mult;

    always_ff @(posedge clock) begin
        if (reset) begin
            state1 <= EMPTY;
            state2 <= EMPTY;
        end else begin
            state1 <= state1_nxt;
            state2 <= state2_nxt;
        end
    end

    // Each delay line is primed once; after that the stage streams until reset.
    always_comb begin
        state1_nxt = state1;
        state2_nxt = state2;
        if (state1 == EMPTY && di_en && cnt1 == CNT1_PRIME)
            state1_nxt = STREAM;
        if (state2 == EMPTY && bf1_do_en && cnt2 == CNT2_PRIME)
            state2_nxt = STREAM;
    end

    always_comb begin
        bf1_go = di_en & (state1 == STREAM);
        bf2_go = bf1_do_en & (state2 == STREAM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt1      <= '0;
            cnt2      <= '0;
            cnt3      <= '0;
            cnt4      <= '0;
            bf1_do_en <= 1'b0;
            bf2_do_en <= 1'b0;
            tw_sr     <= '0;
        end else begin
            if (di_en)     cnt1 <= cnt1 + 1'b1;
            if (bf1_do_en) cnt2 <= cnt2 + 1'b1;
            if (bf2_do_en) cnt3 <= cnt3 + 1'b1;
            if (do_en)     cnt4 <= cnt4 + 1'b1;
            bf1_do_en <= bf1_go;
            bf2_do_en <= bf2_go;
            tw_sr[0]  <= bf2_do_en;
            for (int i = 1; i < TW_LAT; i++)
                tw_sr[i] <= tw_sr[i-1];
        end
    end

    // Twiddle index: low bits times the bit-reversed top two bits.
    always_comb begin
        tw_base = LOG_M'(cnt3[LOG_M-3:0]);
        tw_mult = LOG_M'({cnt3[LOG_M-2], cnt3[LOG_M-1]});
        tw_addr = tw_base * tw_mult;
    end

    assign bf1_bf     = cnt1[LOG_M-1];
    assign bf2_bf     = cnt2[LOG_M-2];
    assign bf2_ct     = cnt2[LOG_M-1] & ~cnt2[LOG_M-2];
    assign do_en      = tw_sr[TW_LAT-1];
    assign frame_done = do_en & (cnt4 == CNT_LAST);

`ifdef SDF_CTRL_FRAMECNT_EN
    always_ff @(posedge clock) begin
        if (reset)
            frame_count <= '0;
        else if (frame_done && frame_count != 16'hFFFF)
            frame_count <= frame_count + 16'd1;
    end
`endif

endmodule
